mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: mem_ack wait limit in cycles, range 1..255.
REQ-002 clk  input  1  system clock, all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dest_bus  input  32  datapath result bus, source for MAR and MDR loads.
REQ-005 MARload, MDRload  input  1 each  load MAR / MDR from dest_bus.
REQ-006 MARoeAddr  input  1  drive MAR onto addr_bus, otherwise addr_bus is high-Z.
REQ-007 MDRoeS2  input  1  drive MDR onto s2_bus, otherwise s2_bus is high-Z.
REQ-008 mem_rd, mem_wr  input  1 each  single-cycle start pulses, read / write at MAR.
REQ-009 mem_size  input  2  00 byte, 01 half, 10 word; 11 reserved and treated as fault.
REQ-010 mem_signed  input  1  sign-extend byte/half reads when 1, zero-extend when 0.
REQ-011 addr_bus, s2_bus  output  32  tri-state datapath buses.
REQ-012 mem_addr  output  32  word-aligned address, {MAR[31:2],2'b00}.
REQ-013 mem_wdata  output  32; mem_be  output  4; mem_we  output  1; mem_req  output  1.
REQ-014 mem_rdata  input  32; mem_ack  input  1  memory read data / completion.
REQ-015 busy, done, fault  output  1 each  status to the control FSM.

Function
REQ-016 FSM states are IDLE, ACCESS, DONE and FAULT.
REQ-017 IDLE with mem_rd or mem_wr and a legal, aligned access -> ACCESS next cycle; mem_req=1 from that cycle.
REQ-018 Misalignment: half with MAR[0]=1, word with MAR[1:0]!=0, or mem_size=11; IDLE -> FAULT with no mem_req.
REQ-019 mem_rd and mem_wr in the same cycle is a fault; FAULT, no memory access.
REQ-020 Size, signedness, direction and MAR[1:0] are latched at start; later input changes have no effect until the next start.
REQ-021 Lanes are big-endian: byte at MAR[1:0]=0 is bits 31:24 and uses mem_be=1000; half at 0 uses be=1100, half at 2 uses be=0011; word uses be=1111.
REQ-022 Write data: byte is MDR[7:0] replicated ×4; half is MDR[15:0] replicated ×2; word is MDR. mem_we=1 throughout ACCESS.
REQ-023 ACCESS holds mem_req, mem_addr, mem_be, mem_we and mem_wdata stable until the cycle mem_ack=1 is sampled.
REQ-024 On ack -> DONE. A read writes the selected lane, right-justified and extended per mem_signed, into MDR on the same edge.
REQ-025 A wait counter clears on entering ACCESS and increments each ack-less cycle; reaching TIMEOUT -> FAULT and drops mem_req.
REQ-026 mem_ack sampled in the same cycle the counter reaches TIMEOUT: ack wins, -> DONE.
REQ-027 DONE lasts exactly one cycle with done=1, then -> IDLE; a start pulse during DONE is ignored.
REQ-028 FAULT asserts fault=1 and stays until reset or a new start pulse; the start pulse is evaluated as in IDLE.
REQ-029 busy=1 in ACCESS only. mem_ack outside ACCESS is ignored.
REQ-030 MARload and MDRload take effect any cycle except ACCESS, where they are ignored; a read ack overrides MDRload.
REQ-031 Best-case read latency: start edge -> ACCESS, ack same cycle -> DONE; data available on s2_bus in DONE.

Reset
REQ-032 Reset forces IDLE; MAR=0, MDR=0, counter=0, mem_req=0, mem_we=0, mem_be=0000.
REQ-033 Reset also forces busy=0, done=0, fault=0; addr_bus and s2_bus are high-Z unless their enables are asserted.
REQ-034 Reset during ACCESS drops mem_req immediately and asynchronously; the access is abandoned with no MDR update.

Structure
REQ-035 A shared dlx_pkg holds mem_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings.
REQ-036 One sub-module, mem_lane: combinational byte-enable, write replication and read extract/extend.

Verification
REQ-037 MAR=0x100, word read, ack after 2 waits, rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, MDR=0xDEADBEEF, done for 1 cycle.
REQ-038 MAR=0x103, byte read signed, rdata=0x000000F0 -> be=0001, MDR=0xFFFFFFF0; same with mem_signed=0 -> MDR=0x000000F0.
REQ-039 MAR=0x202, half write, MDR=0x1234ABCD -> mem_wdata=0xABCDABCD, be=0011, we=1, addr=0x200.
REQ-040 MAR=0x101, word read -> fault=1 next cycle, mem_req never asserted; a later legal start clears fault.
REQ-041 TIMEOUT=3, no ack -> FAULT after 3 wait cycles, mem_req drops; repeat with ack on cycle 3 -> DONE.
REQ-042 reset pulse mid-ACCESS -> mem_req=0 immediately, IDLE, MDR=0; MARoeAddr=0 -> addr_bus=Z.

Source files
------------

// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared size and state encodings for the memory controller
package dlx_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } state_e;

    // Reserved size counts as misaligned so one test covers every illegal start.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = off[0];
            SZ_WORD: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - big-endian byte enables, write replication, read extract/extend
module mem_lane
    import dlx_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sign_ext,
    input  logic [31:0] wsrc,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rvalue
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[15:0] : rdata[31:16];

        be     = 4'b0000;
        wdata  = wsrc;
        rvalue = rdata;
        case (size)
            SZ_BYTE: begin
                be     = 4'b1000 >> off;
                wdata  = {4{wsrc[7:0]}};
                rvalue = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be     = off[1] ? 4'b0011 : 4'b1100;
                wdata  = {2{wsrc[15:0]}};
                rvalue = {{16{sign_ext & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                be     = 4'b1111;
                wdata  = wsrc;
                rvalue = rdata;
            end
            default: begin
                be     = 4'b0000;
                wdata  = wsrc;
                rvalue = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MAR/MDR memory access controller with alignment checks and ack timeout
module mem_ctrl
    import dlx_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dest_bus,
    input  logic        MARload,
    input  logic        MDRload,
    input  logic        MARoeAddr,
    input  logic        MDRoeS2,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    output logic [31:0] addr_bus,
    output logic [31:0] s2_bus,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] mar_q, mar_d, mdr_q, mdr_d, wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic        sign_q, sign_d, wr_q, wr_d;
    logic        req_q, req_d, we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;

    logic        in_access;
    logic [1:0]  lane_size, lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rvalue;

    // Outside ACCESS the lane helper sees the live request; inside, the latched one.
    assign in_access = (state_q == ST_ACCESS);
    assign lane_size = in_access ? size_q : mem_size;
    assign lane_off  = in_access ? off_q  : mar_q[1:0];

    mem_lane u_lane (
        .size     (lane_size),
        .off      (lane_off),
        .sign_ext (sign_q),
        .wsrc     (mdr_q),
        .rdata    (mem_rdata),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .rvalue   (lane_rvalue)
    );

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        off_d   = off_q;
        sign_d  = sign_q;
        wr_d    = wr_q;
        be_d    = be_q;
        wdata_d = wdata_q;

        if (!in_access) begin
            if (MARload) mar_d = dest_bus;
            if (MDRload) mdr_d = dest_bus;
        end

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (mem_rd || mem_wr) begin
                    if ((mem_rd && mem_wr) || misaligned(mem_size, mar_q[1:0])) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = 8'd0;
                        size_d  = mem_size;
                        off_d   = mar_q[1:0];
                        sign_d  = mem_signed;
                        wr_d    = mem_wr;
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so a late ack on the limit cycle still completes.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (!wr_q) mdr_d = lane_rvalue;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d   = (state_d == ST_ACCESS);
        we_d    = req_d && wr_d;
        if (!req_d) be_d = 4'b0000;
        busy_d  = (state_d == ST_ACCESS);
        done_d  = (state_d == ST_DONE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            off_q   <= '0;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            off_q   <= off_d;
            sign_q  <= sign_d;
            wr_q    <= wr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign mem_addr  = {mar_q[31:2], 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign mem_we    = we_q;
    assign mem_req   = req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign addr_bus  = MARoeAddr ? mar_q : 'z;
    assign s2_bus    = MDRoeS2   ? mdr_q : 'z;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with randomized accesses
module tb_mem_ctrl;

    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dest_bus;
    logic        mar_load, mdr_load, mar_oe, mdr_oe;
    logic        mem_rd, mem_wr, mem_signed;
    logic [1:0]  mem_size;
    wire  [31:0] addr_bus, s2_bus;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we, mem_req, mem_ack, busy, done, fault;

    mem_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .dest_bus   (dest_bus),
        .MARload    (mar_load),
        .MDRload    (mdr_load),
        .MARoeAddr  (mar_oe),
        .MDRoeS2    (mdr_oe),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .addr_bus   (addr_bus),
        .s2_bus     (s2_bus),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_we     (mem_we),
        .mem_req    (mem_req),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        is_fault;
        logic [31:0] mdr;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_mar, m_mdr;
    bit          m_fault;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%s expected=%s", name, act, exp);
    endtask

    initial begin : monitor
        req_t cur;
        res_t r;
        bit   in_req;
        bit   prev_fault;
        in_req     = 1'b0;
        prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req     = 1'b0;
                prev_fault = 1'b0;
            end else begin
                check("busy_tracks_req", busy, mem_req);
                if (mem_req) begin
                    if (!in_req) begin
                        if (req_q.size() == 0) fail("unexpected_req", "mem_req=1", "no request");
                        else begin
                            cur    = req_q.pop_front();
                            in_req = 1'b1;
                        end
                    end
                    if (in_req) begin
                        check("mem_addr", mem_addr, cur.addr);
                        check("mem_be", mem_be, cur.be);
                        check("mem_we", mem_we, cur.we);
                        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else begin
                    in_req = 1'b0;
                end
                if (done) begin
                    if (res_q.size() == 0) fail("unexpected_done", "done=1", "no completion");
                    else begin
                        r = res_q.pop_front();
                        check("done_kind_fault", fault, r.is_fault);
                        check("done_mdr", s2_bus, r.mdr);
                    end
                end
                if (fault && !prev_fault) begin
                    if (res_q.size() == 0) fail("unexpected_fault", "fault=1", "no fault");
                    else begin
                        r = res_q.pop_front();
                        check("fault_kind_done", done, !r.is_fault);
                        check("fault_mdr", s2_bus, r.mdr);
                    end
                end
                prev_fault = fault;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] mar, input logic [31:0] mdr);
        dest_bus = mar;
        mar_load = 1'b1;
        tick();
        mar_load = 1'b0;
        dest_bus = mdr;
        mdr_load = 1'b1;
        tick();
        mdr_load = 1'b0;
        dest_bus = $urandom;
        m_mar    = mar;
        m_mdr    = mdr;
    endtask

    // delay > TO means the memory never acks; poke exercises ignored inputs.
    task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                          input int delay, input logic [31:0] rdata, input bit poke);
        bit          bad;
        int          n;
        logic [1:0]  off;
        logic [63:0] mask, lane, wd;
        req_t        q;
        res_t        r;
        off = m_mar[1:0];
        bad = (rd && wr) || (sz == 2'b11) || ((int'(off) % (1 << sz)) != 0);
        if (bad) begin
            if (!m_fault) begin
                r.is_fault = 1'b1;
                r.mdr      = m_mdr;
                res_q.push_back(r);
            end
            m_fault = 1'b1;
        end else begin
            n    = 1 << sz;
            mask = (64'd1 << (8 * n)) - 64'd1;
            wd   = 64'd0;
            for (int i = 0; i < 4 / n; i++) wd |= (64'(m_mdr) & mask) << (8 * n * i);
            q.addr  = {m_mar[31:2], 2'b00};
            q.be    = 4'(((1 << n) - 1) << (4 - int'(off) - n));
            q.we    = wr;
            q.wdata = wd[31:0];
            req_q.push_back(q);
            if (delay <= TO) begin
                if (rd) begin
                    lane = (64'(rdata) >> (8 * (4 - int'(off) - n))) & mask;
                    if (sgn && lane[8 * n - 1]) lane |= ~mask;
                    m_mdr = lane[31:0];
                end
                r.is_fault = 1'b0;
                m_fault    = 1'b0;
            end else begin
                r.is_fault = 1'b1;
                m_fault    = 1'b1;
            end
            r.mdr = m_mdr;
            res_q.push_back(r);
        end

        mem_rd     = rd;
        mem_wr     = wr;
        mem_size   = sz;
        mem_signed = sgn;
        tick();
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'($urandom);
        mem_signed = 1'($urandom);
        if (!bad) begin
            for (int w = 0; w <= TO; w++) begin
                mem_ack   = (w == delay);
                mem_rdata = (w == delay) ? rdata : $urandom;
                if (poke) begin
                    mdr_load = 1'($urandom);
                    mar_load = 1'($urandom);
                    dest_bus = $urandom;
                end
                tick();
                mem_ack  = 1'b0;
                mdr_load = 1'b0;
                mar_load = 1'b0;
                if (w == delay) break;
            end
            if (poke && delay <= TO) begin
                mem_rd  = 1'b1;
                mem_ack = 1'($urandom);
            end
            tick();
            mem_rd  = 1'b0;
            mem_ack = 1'b0;
        end else begin
            tick();
        end
        mem_ack = 1'($urandom);
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic mid_reset();
        req_t q;
        load(32'h0000_0400, 32'hCAFE_F00D);
        q.addr  = 32'h0000_0400;
        q.be    = 4'b1111;
        q.we    = 1'b0;
        q.wdata = 32'h0;
        req_q.push_back(q);
        mem_rd   = 1'b1;
        mem_size = 2'b10;
        tick();
        mem_rd = 1'b0;
        tick();
        check("pre_reset_req", mem_req, 1'b1);
        #3 reset = 1'b1;
        #1 check("async_reset_req", mem_req, 1'b0);
        tick();
        reset   = 1'b0;
        m_mar   = 32'h0;
        m_mdr   = 32'h0;
        m_fault = 1'b0;
        tick();
        check("post_reset_mdr", s2_bus, 32'h0);
        check("post_reset_mar", addr_bus, 32'h0);
        check("post_reset_busy", busy, 1'b0);
        check("post_reset_fault", fault, 1'b0);
        check("post_reset_done", done, 1'b0);
    endtask

    initial begin
        bit         rd, wr;
        logic [1:0] sz;
        reset      = 1'b1;
        dest_bus   = 32'h0;
        mar_load   = 1'b0;
        mdr_load   = 1'b0;
        mar_oe     = 1'b1;
        mdr_oe     = 1'b1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'b00;
        mem_signed = 1'b0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        m_mar      = 32'h0;
        m_mdr      = 32'h0;
        m_fault    = 1'b0;
        #12;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_mar", addr_bus, 32'h0);
        check("rst_mdr", s2_bus, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        load(32'h0000_0100, 32'h1111_2222);
        access(1, 0, 2'b10, 0, 2, 32'hDEAD_BEEF, 0);
        load(32'h0000_0103, 32'h0);
        access(1, 0, 2'b00, 1, 0, 32'h0000_00F0, 0);
        load(32'h0000_0103, 32'h0);
        access(1, 0, 2'b00, 0, 0, 32'h0000_00F0, 0);
        load(32'h0000_0202, 32'h1234_ABCD);
        access(0, 1, 2'b01, 0, 1, 32'h0, 0);
        load(32'h0000_0101, 32'h5555_AAAA);
        access(1, 0, 2'b10, 0, 0, 32'h0, 0);
        load(32'h0000_0100, 32'h5555_AAAA);
        access(1, 0, 2'b10, 0, 0, 32'h0BAD_F00D, 0);
        check("fault_cleared", fault, 1'b0);
        access(1, 0, 2'b10, 0, TO + 1, 32'h0, 0);
        access(1, 0, 2'b10, 0, TO, 32'h7654_3210, 0);
        access(1, 1, 2'b10, 0, 0, 32'h0, 0);
        access(1, 1, 2'b00, 0, 0, 32'h0, 0);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) != 0) load($urandom, $urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rd = 1'($urandom);
            wr = !rd;
            if ($urandom_range(0, 14) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            access(rd, wr, sz, 1'($urandom), $urandom_range(0, TO + 1), $urandom,
                   1'($urandom));
        end

        mid_reset();
        load(32'h0000_0302, 32'h0);
        access(1, 0, 2'b01, 1, 1, 32'h1234_8001, 1);
        tick();
        tick();
        check("req_queue_drained", req_q.size(), 0);
        check("res_queue_drained", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
